jtag_uart_responder: RTL and testbench

//  Avalon-MM slave emulating the JTAG UART data/control registers so the packet driver can
//  run against an on-chip or bench-side host. Host bytes enter an RX FIFO read by the master;

---
 rtl/jtag_uart_responder.sv | 137 +++++++++++++
 tb/tb_jtag_uart_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_uart_responder.sv
// Avalon-MM stand-in for the JTAG UART data/control registers.
// The host side is a byte stream: host bytes fill the RX FIFO and master writes fill the TX FIFO.
module jtag_uart_responder #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BW_FIFO    = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        av_chipselect_i,
  input  logic        av_address_i,
  input  logic        av_read_n_i,
  input  logic        av_write_n_i,
  input  logic [31:0] av_writedata_i,
  output logic [31:0] av_readdata_o,
  output logic        av_waitrequest_o,
  output logic        av_irq_o,
  output logic        dataavailable_o,
  output logic        readyfordata_o,
  input  logic        host_tx_valid_i,
  input  logic [7:0]  host_tx_data_i,
  output logic        host_tx_ready_o,
  output logic        host_rx_valid_o,
  output logic [7:0]  host_rx_data_o,
  input  logic        host_rx_ready_i
);

  localparam logic [BW_FIFO:0] CntFull = (BW_FIFO+1)'(FIFO_DEPTH);

  logic [7:0]         rx_mem_q [FIFO_DEPTH];
  logic [7:0]         tx_mem_q [FIFO_DEPTH];
  logic [BW_FIFO-1:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
  logic [BW_FIFO:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic               wait_q, irq_q, re_q, we_q, ac_q;
  logic               rvalid_q, rvalid_d, ctrl_view_q, ctrl_view_d;
  logic [7:0]         byte_q, byte_d;
  logic [31:0]        rdata_q, rdata_d;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rd_stb, wr_stb, rd_data, rd_ctrl, wr_data, wr_ctrl;
  logic rx_push, rx_pop, tx_push, tx_pop, ri, wi;
  logic [BW_FIFO:0] tx_free;

  always_comb begin
    rx_full  = (rx_cnt_q == CntFull);
    rx_empty = (rx_cnt_q == '0);
    tx_full  = (tx_cnt_q == CntFull);
    tx_empty = (tx_cnt_q == '0);

    rd_stb  = av_chipselect_i & ~wait_q & ~av_read_n_i;
    wr_stb  = av_chipselect_i & ~wait_q & ~av_write_n_i;
    rd_data = rd_stb & ~av_address_i;
    rd_ctrl = rd_stb & av_address_i;
    wr_data = wr_stb & ~av_address_i;
    wr_ctrl = wr_stb & av_address_i;

    // Flags come from registered counts only, so a full FIFO never accepts a push
    // even when a pop happens in the same cycle.
    rx_push = host_tx_valid_i & ~rx_full;
    rx_pop  = rd_data & ~rx_empty;
    tx_push = wr_data & ~tx_full;
    tx_pop  = host_rx_ready_i & ~tx_empty;

    rx_cnt_d = rx_cnt_q + (BW_FIFO+1)'(rx_push) - (BW_FIFO+1)'(rx_pop);
    tx_cnt_d = tx_cnt_q + (BW_FIFO+1)'(tx_push) - (BW_FIFO+1)'(tx_pop);

    ri      = re_q & ~rx_empty;
    wi      = we_q & tx_empty;
    tx_free = CntFull - tx_cnt_q;

    byte_d      = rx_pop ? rx_mem_q[rx_rptr_q] : byte_q;
    rvalid_d    = rd_data ? rx_pop : rvalid_q;
    ctrl_view_d = rd_ctrl | (ctrl_view_q & ~rd_data);

    // Control snapshot holds until the next data read; otherwise live fields track new state.
    if (rd_ctrl) begin
      rdata_d = {16'(tx_free), 5'b0, ac_q, wi, ri, 6'b0, we_q, re_q};
    end else if (ctrl_view_q && !rd_data) begin
      rdata_d = rdata_q;
    end else begin
      rdata_d = {16'(rx_cnt_d), rvalid_d, 1'b0, (tx_cnt_d != CntFull), 5'b0, byte_d};
    end
  end

  always_ff @(posedge clock_i) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= host_tx_data_i;
    if (tx_push) tx_mem_q[tx_wptr_q] <= av_writedata_i[7:0];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      wait_q      <= 1'b1;
      irq_q       <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      ac_q        <= 1'b0;
      rvalid_q    <= 1'b0;
      ctrl_view_q <= 1'b0;
      byte_q      <= '0;
      rdata_q     <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      wait_q      <= 1'b0;
      irq_q       <= ri | wi;
      rvalid_q    <= rvalid_d;
      ctrl_view_q <= ctrl_view_d;
      byte_q      <= byte_d;
      rdata_q     <= rdata_d;
      if (wr_data && tx_full) ac_q <= 1'b1;
      if (wr_ctrl) begin
        re_q <= av_writedata_i[0];
        we_q <= av_writedata_i[1];
        if (av_writedata_i[10]) ac_q <= 1'b0;
      end
    end
  end

  assign av_readdata_o    = rdata_q;
  assign av_waitrequest_o = wait_q;
  assign av_irq_o         = irq_q;
  assign dataavailable_o  = ~rx_empty;
  assign readyfordata_o   = ~tx_full;
  assign host_tx_ready_o  = ~rx_full;
  assign host_rx_valid_o  = ~tx_empty;
  assign host_rx_data_o   = tx_mem_q[tx_rptr_q];

endmodule

// File: tb/tb_jtag_uart_responder.sv
// Bench for jtag_uart_responder: queue-based register model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_jtag_uart_responder;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, addr = 1'b0, rn = 1'b1, wn = 1'b1;
  logic [31:0] wd = '0;
  logic [31:0] rdata;
  logic        wreq, irq, davail, rfd;
  logic        htv = 1'b0;
  logic [7:0]  htd = '0;
  logic        htr, hrv;
  logic [7:0]  hrd;
  logic        hrr = 1'b0;

  always #5 clk = ~clk;

  jtag_uart_responder #(.FIFO_DEPTH(16), .BW_FIFO(4)) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .av_chipselect_i (cs),
    .av_address_i    (addr),
    .av_read_n_i     (rn),
    .av_write_n_i    (wn),
    .av_writedata_i  (wd),
    .av_readdata_o   (rdata),
    .av_waitrequest_o(wreq),
    .av_irq_o        (irq),
    .dataavailable_o (davail),
    .readyfordata_o  (rfd),
    .host_tx_valid_i (htv),
    .host_tx_data_i  (htd),
    .host_tx_ready_o (htr),
    .host_rx_valid_o (hrv),
    .host_rx_data_o  (hrd),
    .host_rx_ready_i (hrr)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two byte queues plus the register bits.
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  bit          m_re, m_we, m_ac, m_rv, m_view, m_irq;
  bit          m_wait = 1'b1;
  logic [7:0]  m_byte = '0;
  logic [31:0] m_rdata = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    int n_rx, n_tx;
    bit rd, wr, irq_n;
    logic [31:0] snap;
    if (rst) begin
      rxq.delete(); txq.delete();
      m_re = 0; m_we = 0; m_ac = 0; m_rv = 0; m_view = 0; m_irq = 0; m_wait = 1;
      m_byte = '0; m_rdata = '0;
    end else begin
      rd = cs && !m_wait && !rn;
      wr = cs && !m_wait && !wn;
      n_rx = rxq.size();
      n_tx = txq.size();
      irq_n = (m_re && n_rx > 0) || (m_we && n_tx == 0);
      snap = {16'(Depth - n_tx), 5'b0, m_ac, (m_we && n_tx == 0), (m_re && n_rx > 0),
              6'b0, m_we, m_re};
      if (rd && !addr) begin
        if (n_rx > 0) begin
          m_byte = rxq.pop_front();
          m_rv = 1;
        end else m_rv = 0;
        m_view = 0;
      end
      if (htv && n_rx < Depth) rxq.push_back(htd);
      if (hrr && n_tx > 0) void'(txq.pop_front());
      if (wr && !addr) begin
        if (n_tx < Depth) txq.push_back(wd[7:0]);
        else m_ac = 1;
      end
      if (wr && addr) begin
        m_re = wd[0];
        m_we = wd[1];
        if (wd[10]) m_ac = 0;
      end
      if (rd && addr) begin
        m_rdata = snap;
        m_view = 1;
      end else if (!m_view) begin
        m_rdata = {16'(rxq.size()), m_rv, 1'b0, (txq.size() < Depth), 5'b0, m_byte};
      end
      m_irq = irq_n;
      m_wait = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("readdata", rdata, m_rdata);
      check("waitrequest", 32'(wreq), 32'(m_wait));
      check("irq", 32'(irq), 32'(m_irq));
      check("dataavailable", 32'(davail), 32'(rxq.size() > 0));
      check("readyfordata", 32'(rfd), 32'(txq.size() < Depth));
      check("host_tx_ready", 32'(htr), 32'(rxq.size() < Depth));
      check("host_rx_valid", 32'(hrv), 32'(txq.size() > 0));
      if (txq.size() > 0) check("host_rx_data", 32'(hrd), 32'(txq[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_readdata", rdata, 32'h0);
    check("rst_wait", 32'(wreq), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    check("wait_after_release", 32'(wreq), 32'h1);
    tick();
    check("wait_clear", 32'(wreq), 32'h0);

    // 2: host bytes read back through the data register
    htv = 1; htd = 8'h41; tick();
    htd = 8'h42; tick();
    htv = 0;
    check("rx_count_2", 32'(rdata[31:16]), 32'd2);
    cs = 1; addr = 0;
    rn = 0; tick(); rn = 1;
    check("rd_41", rdata & 32'h80ff, 32'h8041);
    rn = 0; tick(); rn = 1;
    check("rd_42", rdata & 32'h80ff, 32'h8042);
    rn = 0; tick(); rn = 1;
    check("rd_empty", rdata & 32'h80ff, 32'h0042);

    // 3: single TX byte to host
    wn = 0; wd = 32'h55; tick(); wn = 1;
    check("tx_valid", 32'(hrv), 32'h1);
    check("tx_data", 32'(hrd), 32'h55);
    hrr = 1; tick(); hrr = 0;
    check("tx_popped", 32'(hrv), 32'h0);
    check("wspace", 32'(rdata[13]), 32'h1);

    // 4: TX overflow, AC set and cleared, in-order drain
    for (int i = 0; i < 17; i++) begin
      wn = 0; wd = 32'(i); tick();
      if (i == 15) check("tx_full_rfd", 32'(rfd), 32'h0);
    end
    wn = 1;
    addr = 1; rn = 0; tick(); rn = 1;
    check("ac_set", 32'(rdata[10]), 32'h1);
    check("free_zero", 32'(rdata[31:16]), 32'h0);
    wn = 0; wd = 32'h400; tick(); wn = 1;
    rn = 0; tick(); rn = 1;
    check("ac_clear", 32'(rdata[10]), 32'h0);
    addr = 0;
    hrr = 1;
    for (int i = 0; i < 16; i++) begin
      check("drain_order", 32'(hrd), 32'(i));
      tick();
    end
    hrr = 0;
    check("drained", 32'(hrv), 32'h0);

    // 5: RX full, then concurrent host push and master read over 40 cycles
    htv = 1;
    for (int i = 0; i < 16; i++) begin
      htd = 8'(8'h80 + i); tick();
    end
    htv = 0;
    check("rx_full_avail", 32'(davail), 32'h1);
    check("rx_full_ready", 32'(htr), 32'h0);
    for (int k = 0; k < 40; k++) begin
      htv = 1; htd = 8'(8'ha0 + k); rn = 0; tick();
    end
    htv = 0; rn = 1;
    check("wrap_last_byte", 32'(rdata[7:0]), 32'hb8);
    check("wrap_count", 32'(rdata[31:16]), 32'd15);

    // 6: RX interrupt, then reset mid-burst
    rn = 0; repeat (15) tick(); rn = 1;
    htv = 1; htd = 8'h7e; tick(); htv = 0;
    addr = 1; wn = 0; wd = 32'h1; tick(); wn = 1; addr = 0;
    tick();
    check("irq_set", 32'(irq), 32'h1);
    rn = 0; tick(); rn = 1;
    check("rd_7e", 32'(rdata[7:0]), 32'h7e);
    tick();
    check("irq_clear", 32'(irq), 32'h0);
    htv = 1; wn = 0;
    for (int i = 0; i < 5; i++) begin
      htd = 8'($urandom); wd = $urandom; tick();
    end
    rst = 1; tick();
    rst = 0; htv = 0; wn = 1;
    check("flush_rx", 32'(davail), 32'h0);
    check("flush_tx", 32'(hrv), 32'h0);
    check("flush_rdata", rdata, 32'h0);
    tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      cs   = ($urandom_range(0, 3) != 0);
      addr = ($urandom_range(0, 3) == 0);
      rn   = ($urandom_range(0, 2) != 0);
      wn   = ($urandom_range(0, 2) != 0);
      wd   = $urandom;
      htv  = ((c / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      htd  = 8'($urandom);
      hrr  = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 0; cs = 0; rn = 1; wn = 1; htv = 0; hrr = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
